// File: rtl/bram_byte_write_pkg.sv
// Shared types and constants for the byte-masked block-RAM write adapter.
// Default word width and its all-ones byte-enable mask live here.
package bram_byte_write_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DATA_WIDTH = 32;
  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam logic [MASK_WIDTH-1:0] MASK_FULL = {MASK_WIDTH{1'b1}};

endpackage

// File: rtl/bram_byte_merge.sv
// Per-byte merge of new write data over the word previously read from RAM.
// Purely combinational; a set mask bit selects the write byte.
module bram_byte_merge
  import bram_byte_write_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0]   rdata,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wmask,
  output logic [WIDTH-1:0]   merged
);

  always_comb begin
    merged = rdata;
    for (int i = 0; i < WIDTH / 8; i++) begin
      if (wmask[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/bram_byte_write.sv
// Byte-masked write adapter in front of a block-RAM slave: partial writes
// become read-modify-write, full writes and reads go straight through.
module bram_byte_write
  import bram_byte_write_pkg::*;
#(
  parameter int WIDTH    = DATA_WIDTH,
  parameter int ADDR_LSH = 2
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_request,
  input  logic               i_rw,
  input  logic [31:0]        i_address,
  input  logic [WIDTH-1:0]   i_wdata,
  input  logic [WIDTH/8-1:0] i_wmask,
  output logic [WIDTH-1:0]   o_rdata,
  output logic               o_ready,
  output logic               o_error,
  output logic               o_bus_request,
  output logic               o_bus_rw,
  output logic [31:0]        o_bus_address,
  output logic [WIDTH-1:0]   o_bus_wdata,
  input  logic [WIDTH-1:0]   i_bus_rdata,
  input  logic               i_bus_ready,
  input  logic               i_bus_valid
);

  localparam int MW = WIDTH / 8;
  localparam logic [31:0] LOW_BITS = 32'((64'd1 << ADDR_LSH) - 64'd1);

  state_t           state;
  logic             first;
  logic             err;
  logic             rw_q;
  logic [31:0]      addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] result;
  logic [MW-1:0]    wmask_q;
  logic [WIDTH-1:0] merged;
  logic             accept;

  // The RAM ready is a registered echo of our request, so the value seen in
  // the first cycle of any bus state belongs to the previous access.
  assign accept = i_bus_ready && !first;

  bram_byte_merge #(.WIDTH(WIDTH)) u_merge (
    .rdata  (rdata_q),
    .wdata  (wdata_q),
    .wmask  (wmask_q),
    .merged (merged)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state   <= IDLE;
      first   <= 1'b0;
      err     <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wmask_q <= '0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_request) begin
            rw_q    <= i_rw;
            addr_q  <= i_address & ~LOW_BITS;
            wdata_q <= i_wdata;
            wmask_q <= i_wmask;
            err     <= 1'b0;
            result  <= '0;
            first   <= 1'b1;
            if (!i_rw)                state <= READ;
            else if (i_wmask == '0)   state <= DONE;
            else if (&i_wmask)        state <= WRITE;
            else                      state <= READ;
          end
        end
        READ: begin
          first <= 1'b0;
          if (accept) begin
            rdata_q <= i_bus_rdata;
            result  <= i_bus_rdata;
            err     <= err | !i_bus_valid;
            // An invalid read aborts the RMW before any write is issued.
            if (!rw_q || !i_bus_valid) begin
              state <= DONE;
            end else begin
              state <= WRITE;
              first <= 1'b1;
            end
          end
        end
        WRITE: begin
          first <= 1'b0;
          if (accept) begin
            result <= merged;
            err    <= err | !i_bus_valid;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_bus_request = (state == READ) || (state == WRITE);
  assign o_bus_rw      = (state == WRITE);
  assign o_ready       = (state == DONE);
  assign o_bus_address = addr_q;
  assign o_bus_wdata   = merged;
  assign o_rdata       = result;
  assign o_error       = err;

endmodule

// File: tb/tb_bram_byte_write.sv
// Bench for bram_byte_write: directed cases then random traffic against a
// behavioural memory model; a small RAM model answers bus cycles.
module tb_bram_byte_write;
  import bram_byte_write_pkg::*;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_request = 1'b0;
  logic        i_rw = 1'b0;
  logic [31:0] i_address = '0;
  logic [31:0] i_wdata = '0;
  logic [3:0]  i_wmask = '0;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic        o_error;
  logic        o_bus_request;
  logic        o_bus_rw;
  logic [31:0] o_bus_address;
  logic [31:0] o_bus_wdata;
  logic [31:0] i_bus_rdata = '0;
  logic        i_bus_ready = 1'b0;
  logic        i_bus_valid = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int tn = 0;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  bram_byte_write #(.WIDTH(32), .ADDR_LSH(2)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_request     (i_request),
    .i_rw          (i_rw),
    .i_address     (i_address),
    .i_wdata       (i_wdata),
    .i_wmask       (i_wmask),
    .o_rdata       (o_rdata),
    .o_ready       (o_ready),
    .o_error       (o_error),
    .o_bus_request (o_bus_request),
    .o_bus_rw      (o_bus_rw),
    .o_bus_address (o_bus_address),
    .o_bus_wdata   (o_bus_wdata),
    .i_bus_rdata   (i_bus_rdata),
    .i_bus_ready   (i_bus_ready),
    .i_bus_valid   (i_bus_valid)
  );

  always #5 i_clock = ~i_clock;

  // RAM of 0x400 words: registered ready, data and in-range flag.
  always @(posedge i_clock) begin
    i_bus_ready <= o_bus_request;
    if (o_bus_request) begin
      if (o_bus_address[31:2] < 30'd1024) begin
        i_bus_valid <= 1'b1;
        i_bus_rdata <= mem[o_bus_address[11:2]];
        if (o_bus_rw) mem[o_bus_address[11:2]] <= o_bus_wdata;
      end else begin
        i_bus_valid <= 1'b0;
        i_bus_rdata <= '0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (txn %0d): observed=%h expected=%h", tag, tn, obs, exp);
    end
  endtask

  task automatic txn(input logic rw, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] m, input bit hold, input int extra);
    logic [29:0] word;
    bit          inr;
    logic [31:0] old, merged, exp_rd;
    int          exp_lat, exp_nr, exp_nw, lat, nr, nw;
    bit          exp_err, chk_rd, addr_bad;
    tn++;
    word = a[31:2];
    inr  = (word < 30'd1024);
    old  = inr ? ref_mem[word[9:0]] : 32'h0;
    merged = '0;
    for (int b = 0; b < 4; b++) merged[8*b +: 8] = m[b] ? d[8*b +: 8] : old[8*b +: 8];
    chk_rd = 1; exp_nr = 0; exp_nw = 0; exp_err = !inr; exp_rd = merged;
    if (!rw) begin
      exp_lat = 3; exp_nr = 2; exp_rd = old;
    end else if (m == 4'b0000) begin
      exp_lat = 1; exp_err = 0; exp_rd = 32'h0;
    end else if (m == MASK_FULL) begin
      exp_lat = 3; exp_nw = 2;
    end else if (inr) begin
      exp_lat = 5; exp_nr = 2; exp_nw = 2;
    end else begin
      exp_lat = 3; exp_nr = 2; chk_rd = 0;
    end
    if (rw && m != 4'b0000 && inr) ref_mem[word[9:0]] = merged;
    exp_lat += extra;

    i_request = 1'b1; i_rw = rw; i_address = a; i_wdata = d; i_wmask = m;
    lat = 0; nr = 0; nw = 0; addr_bad = 0;
    do begin
      @(posedge i_clock); #1;
      lat++;
      if (o_bus_request) begin
        if (o_bus_rw) nw++; else nr++;
        if (o_bus_address !== {a[31:2], 2'b00}) addr_bad = 1;
      end
    end while (!o_ready && lat < 50);

    check("latency", 32'(lat), 32'(exp_lat));
    check("error", {31'b0, o_error}, {31'b0, exp_err});
    if (chk_rd) check("rdata", o_rdata, exp_rd);
    check("bus_reads", 32'(nr), 32'(exp_nr));
    check("bus_writes", 32'(nw), 32'(exp_nw));
    check("bus_address", {31'b0, addr_bad}, 32'h0);
    if (rw && inr) check("ram_word", mem[word[9:0]], ref_mem[word[9:0]]);

    if (!hold) begin
      i_request = 1'b0;
      @(posedge i_clock); #1;
      check("ready_pulse", {31'b0, o_ready}, 32'h0);
      if (chk_rd) check("rdata_hold", o_rdata, exp_rd);
    end
  endtask

  initial begin
    int k, nready;
    logic [31:0] v;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[10'h100] = 32'hDEADBEEF;
    ref_mem[10'h100] = 32'hDEADBEEF;

    #1;
    check("rst_bus_request", {31'b0, o_bus_request}, 32'h0);
    check("rst_bus_rw", {31'b0, o_bus_rw}, 32'h0);
    check("rst_ready", {31'b0, o_ready}, 32'h0);
    check("rst_error", {31'b0, o_error}, 32'h0);
    check("rst_rdata", o_rdata, 32'h0);
    check("rst_bus_address", o_bus_address, 32'h0);
    check("rst_bus_wdata", o_bus_wdata, 32'h0);
    repeat (2) @(posedge i_clock);
    #1 i_reset = 1'b0;
    @(posedge i_clock); #1;

    txn(1'b0, 32'h0000_0402, 32'h0, 4'b0000, 0, 0);          // read
    txn(1'b1, 32'h0000_0404, 32'h1122_3344, 4'b1111, 0, 0);  // full write
    txn(1'b1, 32'h0000_0404, 32'hAABB_CCDD, 4'b0101, 0, 0);  // RMW
    check("rmw_word", mem[10'h101], 32'h11BB_33DD);
    txn(1'b1, 32'h0000_0408, 32'h5555_5555, 4'b0000, 0, 0);  // mask 0
    txn(1'b1, 32'h0000_1000, 32'h1234_5678, 4'b0011, 0, 0);  // out of range RMW

    // Reset while the RMW is in its write phase.
    tn++;
    i_request = 1'b1; i_rw = 1'b1; i_address = 32'h0000_0800;
    i_wdata = 32'hCAFE_F00D; i_wmask = 4'b0011;
    k = 0;
    do begin
      @(posedge i_clock); #1; k++;
    end while (!o_bus_rw && k < 20);
    check("rst_reach_write", {31'b0, o_bus_rw}, 32'h1);
    i_reset = 1'b1;
    #1;
    check("rst_async_drop", {31'b0, o_bus_request}, 32'h0);
    check("rst_async_ready", {31'b0, o_ready}, 32'h0);
    check("rst_async_rdata", o_rdata, 32'h0);
    i_request = 1'b0;
    repeat (2) @(posedge i_clock);
    #1 i_reset = 1'b0;
    nready = 0;
    repeat (6) begin
      @(posedge i_clock); #1;
      if (o_ready) nready++;
    end
    check("rst_no_ready", 32'(nready), 32'h0);
    check("rst_ram_untouched", mem[10'h200], ref_mem[10'h200]);

    // Back-to-back: second request held straight through the first DONE.
    txn(1'b0, 32'h0000_0400, 32'h0, 4'b0000, 1, 0);
    txn(1'b1, 32'h0000_040C, 32'h0BAD_F00D, 4'b1111, 0, 1);

    for (int i = 0; i < 60; i++) begin
      txn(1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'h13FF)),
          $urandom, 4'($urandom_range(0, 15)), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_byte_write.md
# bram_byte_write

Byte-masked write adapter placed directly upstream of the block-RAM slave. It accepts CPU-side word accesses with a per-byte write mask and turns them into whole-word RAM cycles. Partial writes become a read-modify-write sequence; full-mask writes and reads pass through as single RAM accesses. Read data and the RAM valid/error status are returned to the requester with a one-cycle ready pulse.

## Interface
Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of 8. The mask width MW is WIDTH/8.
- ADDR_LSH, 2, byte-to-word address shift used by the RAM; equals log2(MW).

Ports:
- i_clock  in  1  the single clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_request  in  1  CPU request; held high until o_ready.
- i_rw  in  1  0 = read, 1 = write.
- i_address  in  32  byte address.
- i_wdata  in  WIDTH  write data.
- i_wmask  in  MW  byte enables; bit i selects byte i (bits [8i+7:8i]).
- o_rdata  out  WIDTH  read word (read) or merged word written (write).
- o_ready  out  1  one-cycle completion pulse.
- o_error  out  1  qualified by o_ready; 1 if any RAM access returned invalid.
- o_bus_request  out  1  RAM request.
- o_bus_rw  out  1  RAM direction.
- o_bus_address  out  32  word-aligned address: i_address with bits [ADDR_LSH-1:0] cleared.
- o_bus_wdata  out  WIDTH  merged write word.
- i_bus_rdata  in  WIDTH  RAM read data.
- i_bus_ready  in  1  RAM ready. It is the registered copy of o_bus_request, so it stays high one cycle after the request drops.
- i_bus_valid  in  1  RAM address-in-range flag, sampled together with i_bus_ready.

## Operation
- **Capture.** In IDLE with i_request=1, the block latches rw, the aligned address, wdata and wmask. The inputs are not re-sampled until the next IDLE.
- **States:** IDLE, READ, WRITE, DONE.
- **Transitions out of IDLE** (on request):
  - read goes to READ;
  - write with wmask all ones goes to WRITE;
  - write with wmask = 0 goes to DONE, with no RAM access and o_rdata = 0;
  - any other write goes to READ.
- **READ:**
  - o_bus_request=1, o_bus_rw=0.
  - On an accepted i_bus_ready, the block latches i_bus_rdata and ORs !i_bus_valid into the error flag.
  - Next state is DONE for a read, or for an RMW whose read was invalid (the write is skipped). Otherwise next state is WRITE.
- **WRITE:**
  - o_bus_request=1, o_bus_rw=1, o_bus_wdata = merged word.
  - For byte i, the merged byte is wdata byte i when wmask[i]=1, else the latched rdata byte i. A full-mask write uses wdata unchanged.
  - On an accepted i_bus_ready, the block ORs in !i_bus_valid and goes to DONE.
- **DONE:**
  - o_ready=1 and o_bus_request=0 for exactly one cycle, then IDLE.
  - o_rdata and o_error are stable during DONE and hold their values in IDLE until the next capture.
- **Accepting i_bus_ready.** i_bus_ready is ignored in the first cycle of every READ or WRITE state, because that value is stale from a previous request. It is accepted from the second cycle onward. A "first" flag register implements this rule.
- **Duplicate accesses.** The RAM repeats the access in the cycle ready is accepted. Duplicate reads and identical duplicate writes are harmless and permitted.
- **Back-to-back requests.** If i_request is still high in the cycle after DONE, it is a new transaction captured in IDLE.

## Timing
- **Reset values.** All outputs are 0; state is IDLE; latches and the error flag are 0. Reset mid-transaction drops o_bus_request asynchronously and abandons the transaction with no o_ready.
- **Output decoding.** o_bus_request, o_bus_rw and o_ready decode from registered state only, with no input-to-output combinational path.
- **Latency** (cycle 0 = IDLE with request):
  - read or full-mask write: RAM request in cycles 1–2, o_ready in cycle 3;
  - RMW: READ in cycles 1–2, WRITE in cycles 3–4, o_ready in cycle 5;
  - mask 0: o_ready in cycle 1;
  - RMW whose read is invalid: o_ready in cycle 3 with o_error=1.
- **Slower RAM.** If i_bus_ready is late, the block stays in READ or WRITE until it is accepted. There is no timeout.
- **No throughput overlap:** one transaction is in flight at a time.

## Structure
- Shared package holds:
  - the state enum typedef: IDLE, READ, WRITE, DONE;
  - a localparam for the all-ones mask constant derived from WIDTH.
- Sub-module bram_byte_merge holds the combinational per-byte mux. Inputs: rdata, wdata, wmask. Output: merged word.
- The FSM, capture registers, first flag and error flag live in the top module.

## Test plan
- **Read:** RAM word 0x100 holds 0xDEADBEEF; read at 0x402 gives o_bus_address 0x400, o_rdata 0xDEADBEEF, o_error 0, o_ready in cycle 3.
- **Full write:** write 0x11223344 at 0x404 with mask 1111 gives a single RAM write, o_ready in cycle 3, RAM word 0x101 = 0x11223344, and no RAM read issued.
- **RMW:** word 0x101 holds 0x11223344; write 0xAABBCCDD with mask 0101 gives RAM word 0x11BB33DD, o_rdata 0x11BB33DD, o_ready in cycle 5.
- **Mask 0:** write with mask 0000 gives o_ready in cycle 1, o_bus_request never high, and RAM unchanged.
- **Out of range:** RAM SIZE 0x400, RMW at 0x1000 gives i_bus_valid=0 on read, no write cycle, o_ready in cycle 3 with o_error=1.
- **Reset and back-to-back:**
  - assert i_reset during WRITE: o_bus_request drops at once and there is no o_ready;
  - afterwards, two consecutive held requests each complete, the second starting the cycle after the first DONE.
